// File: rtl/irq_arbiter_pkg.sv
// irq_arbiter_pkg
//   Shared constants and helpers for the interrupt arbiter:
//   - FSM state encoding (IRQA_IDLE / IRQA_REQ / IRQA_SERVE)
//   - mcause codes: machine timer (source 0) and the base code for sources 1..N-1
//   - irq_cause_of(): maps a source index to its mcause value
package irq_arbiter_pkg;

  typedef enum logic [1:0] {
    IRQA_IDLE  = 2'd0,
    IRQA_REQ   = 2'd1,
    IRQA_SERVE = 2'd2
  } irqa_state_t;

  // Machine timer interrupt cause, shared with the rest of the core.
  localparam logic [31:0] CLOCK_INT_MCAUSE    = 32'h8000_0007;
  // Source k >= 1 reports EXT_INT_MCAUSE_BASE + (k-1).
  localparam logic [31:0] EXT_INT_MCAUSE_BASE = 32'h8000_0010;

  function automatic logic [31:0] irq_cause_of(input logic [31:0] id);
    if (id == 32'd0) begin
      return CLOCK_INT_MCAUSE;
    end
    return EXT_INT_MCAUSE_BASE + (id - 32'd1);
  endfunction

endpackage

// File: rtl/irq_pending_cell.sv
// irq_pending_cell
//   One interrupt source: a single sampling stage, edge detector and the
//   pending flop.
// Ports:
//   clk       in   system clock
//   clr       in   synchronous active-high reset
//   src       in   raw (unregistered) interrupt line
//   edge_mode in   1 = rising-edge triggered, 0 = level (static)
//   clr_pend  in   acknowledge for this source (edge mode only)
//   pending   out  registered pending bit
module irq_pending_cell (
  input  logic clk,
  input  logic clr,
  input  logic src,
  input  logic edge_mode,
  input  logic clr_pend,
  output logic pending
);

  logic s_q;
  logic s_qq;
  logic rise;

  assign rise = s_q & ~s_qq;

  always_ff @(posedge clk) begin
    if (clr) begin
      s_q     <= 1'b0;
      s_qq    <= 1'b0;
      pending <= 1'b0;
    end else begin
      s_q  <= src;
      s_qq <= s_q;
      if (edge_mode) begin
        // A new edge in the same cycle as the acknowledge must not be lost,
        // so the set term dominates the clear.
        pending <= rise | (pending & ~clr_pend);
      end else begin
        // Level sources follow the line; the handler clears the device.
        pending <= s_q;
      end
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// irq_arbiter
//   Latches up to N_SRC interrupt sources, masks them with per-source and
//   global enables, and presents a single fixed-priority (lowest index wins)
//   request to the interrupt manager. Only one handler is in service at a
//   time: no new request is raised until irq_done.
// Parameters:
//   N_SRC  number of sources (2..16), source 0 is the machine timer
//   ID_W   width of the source index, clog2(N_SRC)
// Ports:
//   clk, clr         clock, synchronous active-high reset
//   src_irq          raw source lines
//   src_edge         per-source mode, 1 = edge, 0 = level (static)
//   src_en           per-source enable (mie)
//   global_int_en    mstatus.MIE
//   irq_ack          request accepted (one-cycle pulse)
//   irq_done         MRET completed (one-cycle pulse)
//   irq_req          registered request
//   irq_id           requesting / in-service source index
//   irq_cause        mcause for irq_id (decoded from the registered id)
//   pending          unmasked pending bits
//   busy             handler in service
module irq_arbiter
  import irq_arbiter_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int ID_W  = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [N_SRC-1:0]  src_irq,
  input  logic [N_SRC-1:0]  src_edge,
  input  logic [N_SRC-1:0]  src_en,
  input  logic              global_int_en,
  input  logic              irq_ack,
  input  logic              irq_done,
  output logic              irq_req,
  output logic [ID_W-1:0]   irq_id,
  output logic [31:0]       irq_cause,
  output logic [N_SRC-1:0]  pending,
  output logic              busy
);

  irqa_state_t      state;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] clr_pend;
  logic             any_eligible;
  logic [ID_W-1:0]  win_id;
  logic             ack_taken;

  // Acknowledge only means something while a request is outstanding.
  assign ack_taken = irq_ack && (state == IRQA_REQ);

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    assign clr_pend[i] = ack_taken && (irq_id == ID_W'(i));

    irq_pending_cell u_cell (
      .clk       (clk),
      .clr       (clr),
      .src       (src_irq[i]),
      .edge_mode (src_edge[i]),
      .clr_pend  (clr_pend[i]),
      .pending   (pending[i])
    );
  end

  assign eligible     = pending & src_en & {N_SRC{global_int_en}};
  assign any_eligible = |eligible;

  // Fixed priority: scanning downwards leaves the lowest eligible index.
  always_comb begin
    win_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_id = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= IRQA_IDLE;
      irq_req <= 1'b0;
      busy    <= 1'b0;
      irq_id  <= '0;
    end else begin
      case (state)
        IRQA_IDLE: begin
          if (any_eligible) begin
            irq_id  <= win_id;
            irq_req <= 1'b1;
            state   <= IRQA_REQ;
          end
        end
        IRQA_REQ: begin
          // irq_id stays frozen; a higher-priority arrival does not preempt.
          // The ack takes precedence over a simultaneous withdrawal.
          if (irq_ack) begin
            irq_req <= 1'b0;
            busy    <= 1'b1;
            state   <= IRQA_SERVE;
          end else if (!eligible[irq_id]) begin
            irq_req <= 1'b0;
            state   <= IRQA_IDLE;
          end
        end
        IRQA_SERVE: begin
          if (irq_done) begin
            busy  <= 1'b0;
            state <= IRQA_IDLE;
          end
        end
        default: begin
          state   <= IRQA_IDLE;
          irq_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  assign irq_cause = irq_cause_of(32'(irq_id));

endmodule
